// File: rtl/btn_script_player_pkg.sv
// Shared definitions for the button script player.
// Holds the op encodings, FSM state encodings, entry field widths and a
// helper that decodes an op into the three button levels.
package btn_script_player_pkg;

  // Width of the op field at the top of each script entry.
  localparam int OP_W           = 2;
  // Default width of the hold-cycle field at the bottom of each entry.
  localparam int HOLD_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LEFT  = 2'b01,
    OP_RIGHT = 2'b10,
    OP_JUMP  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRESS   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef struct packed {
    logic left;
    logic right;
    logic jump;
  } btn_t;

  // At most one button is ever returned high; NOP returns all low.
  function automatic btn_t op_to_btn(op_e op);
    btn_t b;
    b = '0;
    case (op)
      OP_LEFT:  b.left  = 1'b1;
      OP_RIGHT: b.right = 1'b1;
      OP_JUMP:  b.jump  = 1'b1;
      default:  b       = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/btn_script_player_if.sv
// Control/status bundle between a script requester and the player.
//   start, abort                 : requester -> player
//   left_btn, right_btn, jump_btn: player -> character block (button levels)
//   busy, done, step_idx         : player status
// slave modport is used by the player, master by whoever drives it.
interface btn_script_player_if #(
  parameter int SCRIPT_LEN = 16
) ();
  localparam int IDX_W = $clog2(SCRIPT_LEN);

  logic             start;
  logic             abort;
  logic             left_btn;
  logic             right_btn;
  logic             jump_btn;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] step_idx;

  modport slave (
    input  start, abort,
    output left_btn, right_btn, jump_btn, busy, done, step_idx
  );

  modport master (
    output start, abort,
    input  left_btn, right_btn, jump_btn, busy, done, step_idx
  );
endinterface

// File: rtl/btn_script_rom.sv
// Combinational script ROM.
//   step_idx : entry index
//   entry    : {op, hold}
// With OVR_EN set, the contents come from the flattened OVR_ROM vector
// (entry i at bits [i*ENTRY_W +: ENTRY_W]); otherwise the built-in demo
// script is used: LEFT 3, JUMP 5, RIGHT 2, then end markers.
module btn_script_rom
  import btn_script_player_pkg::*;
#(
  parameter int  SCRIPT_LEN = 16,
  parameter int  HOLD_WIDTH = HOLD_W_DEFAULT,
  parameter bit  OVR_EN     = 1'b0,
  parameter logic [SCRIPT_LEN*(OP_W+HOLD_WIDTH)-1:0] OVR_ROM = '0
) (
  input  logic [$clog2(SCRIPT_LEN)-1:0] step_idx,
  output logic [OP_W+HOLD_WIDTH-1:0]    entry
);
  localparam int ENTRY_W = OP_W + HOLD_WIDTH;

  always_comb begin
    entry = '0;
    if (OVR_EN) begin
      entry = OVR_ROM[int'(step_idx)*ENTRY_W +: ENTRY_W];
    end else begin
      case (int'(step_idx))
        0:       entry = {OP_LEFT,  HOLD_WIDTH'(3)};
        1:       entry = {OP_JUMP,  HOLD_WIDTH'(5)};
        2:       entry = {OP_RIGHT, HOLD_WIDTH'(2)};
        default: entry = {OP_NOP,   HOLD_WIDTH'(0)};
      endcase
    end
  end
endmodule

// File: rtl/btn_script_player.sv
// Button script player: on a start rising edge, walks a ROM of
// {op, hold} entries and drives one button per entry for hold cycles,
// separated by GAP_CYCLES all-released cycles. An entry with hold 0
// ends the script early.
//   debug_char_clk : clock
//   sys_rst_n      : asynchronous active-low reset
//   bus (slave)    : start/abort in; registered buttons, busy, done,
//                    step_idx out
module btn_script_player
  import btn_script_player_pkg::*;
#(
  parameter int  SCRIPT_LEN = 16,
  parameter int  HOLD_WIDTH = HOLD_W_DEFAULT,
  parameter int  GAP_CYCLES = 2,
  parameter bit  OVR_EN     = 1'b0,
  parameter logic [SCRIPT_LEN*(OP_W+HOLD_WIDTH)-1:0] OVR_ROM = '0
) (
  input logic               debug_char_clk,
  input logic               sys_rst_n,
  btn_script_player_if.slave bus
);
  localparam int IDX_W   = $clog2(SCRIPT_LEN);
  localparam int ENTRY_W = OP_W + HOLD_WIDTH;
  // The LOAD cycle of the next entry is itself a released cycle, so
  // RELEASE only needs to cover the remainder of the gap.
  localparam int REL_CYC = GAP_CYCLES - 1;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  state_e                state, state_nxt;
  logic [IDX_W-1:0]      step_idx, step_idx_nxt;
  logic [HOLD_WIDTH-1:0] hold_cnt, hold_cnt_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
  op_e                   op_q, op_nxt;
  btn_t                  btn_q, btn_nxt;
  logic                  done_q, done_nxt;
  logic                  start_d;
  logic                  start_armed;
  logic                  launch;
  logic                  entry_end;
  logic [ENTRY_W-1:0]    entry;
  op_e                   rom_op;
  logic [HOLD_WIDTH-1:0] rom_hold;

  btn_script_rom #(
    .SCRIPT_LEN (SCRIPT_LEN),
    .HOLD_WIDTH (HOLD_WIDTH),
    .OVR_EN     (OVR_EN),
    .OVR_ROM    (OVR_ROM)
  ) u_rom (
    .step_idx (step_idx),
    .entry    (entry)
  );

  assign rom_op   = op_e'(entry[ENTRY_W-1 -: OP_W]);
  assign rom_hold = entry[HOLD_WIDTH-1:0];

  // start_armed stays low after reset until start has been seen low, so a
  // start level held across reset release cannot look like a fresh edge.
  assign launch = bus.start & ~start_d & start_armed;

  always_ff @(posedge debug_char_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      step_idx    <= '0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      op_q        <= OP_NOP;
      btn_q       <= '0;
      done_q      <= 1'b0;
      start_d     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      state       <= state_nxt;
      step_idx    <= step_idx_nxt;
      hold_cnt    <= hold_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      op_q        <= op_nxt;
      btn_q       <= btn_nxt;
      done_q      <= done_nxt;
      start_d     <= bus.start;
      start_armed <= start_armed | ~bus.start;
    end
  end

  always_comb begin
    state_nxt    = state;
    step_idx_nxt = step_idx;
    hold_cnt_nxt = hold_cnt;
    gap_cnt_nxt  = gap_cnt;
    op_nxt       = op_q;
    entry_end    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (launch) begin
          state_nxt    = ST_LOAD;
          step_idx_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (rom_hold == '0) begin
          state_nxt = ST_DONE;
        end else begin
          hold_cnt_nxt = rom_hold;
          op_nxt       = rom_op;
          state_nxt    = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (hold_cnt == HOLD_WIDTH'(1)) begin
          if (REL_CYC > 0) begin
            state_nxt   = ST_RELEASE;
            gap_cnt_nxt = GAP_W'(REL_CYC);
          end else begin
            entry_end = 1'b1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt - HOLD_WIDTH'(1);
        end
      end
      ST_RELEASE: begin
        if (gap_cnt == GAP_W'(1)) begin
          entry_end = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Last entry finishes the script; there is no wrap back to entry 0.
    if (entry_end) begin
      if (step_idx == IDX_W'(SCRIPT_LEN - 1)) begin
        state_nxt = ST_DONE;
      end else begin
        step_idx_nxt = step_idx + IDX_W'(1);
        state_nxt    = ST_LOAD;
      end
    end

    if (bus.abort) begin
      state_nxt    = ST_IDLE;
      step_idx_nxt = '0;
      hold_cnt_nxt = '0;
      gap_cnt_nxt  = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    btn_nxt  = (state_nxt == ST_PRESS) ? op_to_btn(op_nxt) : '0;
    done_nxt = (state_nxt == ST_DONE);
  end

  assign bus.left_btn  = btn_q.left;
  assign bus.right_btn = btn_q.right;
  assign bus.jump_btn  = btn_q.jump;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx;

endmodule
